sid_bus_sequencer: RTL
======================

Name: sid_bus_sequencer

Overview:
- Bus initiator for the SID register interface: accepts timed register-access commands from the loader/player side, buffers them in a FIFO, and issues them on the SID bus (cs/we/addr/data) at 1 MHz tick resolution.
- Read commands (e.g. OSC3 at 0x1B, ENV3 at 0x1C) return the SID's data_out on a response port.
- Sits between the SID-file player/loader logic and the SID core, on the SID's clk/ce_1m domain.

Parameters:
- DUAL, 0, 1 = two SID chips, so cs is 2 bits and cmd_chip selects between them; 0 = one chip, cmd_chip ignored.
- FIFO_DEPTH, 16, command FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock, same as the SID core.
- reset_n  in  1  asynchronous, active-low reset.
- ce_1m  in  1  1 MHz clock enable, one clk wide.
- flush  in  1  synchronous: empty the FIFO and abort a pending wait.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_delay  in  16  ce_1m ticks to wait before this access.
- cmd_chip  in  1  target chip index.
- cmd_rd  in  1  1 = read, 0 = write.
- cmd_addr  in  5  SID register address.
- cmd_data  in  8  write data.
- cs  out  N (N = DUAL?2:1)  SID chip selects.
- we  out  1  write strobe.
- addr  out  5  register address to the SID.
- data_out  out  8  write data to the SID's data_in.
- sid_rdata  in  8  SID data_out.
- rsp_valid  out  1  one-clk read-response strobe.
- rsp_data  out  8  read data.
- busy  out  1  FIFO non-empty or an access in flight.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, state IDLE, delay counter 0. Outputs: cs=0, we=0, addr=0, data_out=0, rsp_valid=0, rsp_data=0, busy=0, level=0, cmd_ready=1.
- FIFO:
  - Each entry is {delay, chip, rd, addr, data}.
  - Push on cmd_valid&cmd_ready. cmd_ready = (level != FIFO_DEPTH).
  - Pop occurs on the IDLE→WAIT transition.
  - Simultaneous push and pop in the same cycle: level unchanged.
  - Push when full: cannot happen, since cmd_ready=0.
- States:
  - IDLE: if FIFO non-empty → pop, load cnt=cmd_delay, go to WAIT.
  - WAIT: on each ce_1m with cnt≠0, cnt decrements. On a ce_1m with cnt==0, go to ACCESS (latency from the zero-crossing ce_1m is 1 clk). A delay of 0 means the access fires on the first ce_1m after the pop.
  - ACCESS: exactly one clk. cs[chip]=1; we=~rd; addr and data_out driven from the entry. Write → IDLE. Read → CAPTURE.
  - CAPTURE: one clk. Sample sid_rdata, set rsp_data, pulse rsp_valid=1 for one clk, then → IDLE.
- Bus outputs:
  - cs and we are registered, and are zero in every state except ACCESS.
  - addr and data_out hold their last values outside ACCESS.
- Access rate: at most one access per ce_1m period. A new WAIT cannot complete on the same ce_1m that launched the previous ACCESS.
- Back-to-back delay-0 commands issue on consecutive ce_1m ticks.
- Chip select:
  - DUAL=0: cs is 1 bit, cmd_chip ignored.
  - DUAL=1: cs = 2'b01 for chip 0, 2'b10 for chip 1. Never both.
- Addresses 0x19–0x1F with rd=0: issued unchanged; the SID ignores them.
- flush:
  - Clears the FIFO and forces WAIT → IDLE.
  - An ACCESS or CAPTURE already in progress completes first; flush does not truncate a cs pulse.
  - A cmd_valid coincident with flush is discarded.
- busy = (level≠0) | (state≠IDLE).
- cnt is 16-bit, counts down only, no wrap. A delay of 0xFFFF waits 65535 ticks, then fires on the next tick.

Test Plan:
- Reset, then one write {delay=0, addr=0x18, data=0x0F} → exactly one clk with cs=1, we=1, addr=0x18, data_out=0x0F on the first ce_1m after the pop; busy drops the following cycle.
- Writes with delay=3 then delay=0, with ce_1m every 32 clks → first cs pulse 4 ce_1m ticks after the pop; second pulse exactly 1 tick later.
- Read {addr=0x1C}, with the SID model returning 0xA5 → one clk with cs=1, we=0; one clk later rsp_valid=1, rsp_data=0xA5.
- FIFO_DEPTH=16: push 16 commands while the sequencer is stalled on delay=0xFFFF → cmd_ready=0 and level=16. After the first pop, cmd_ready=1.
- DUAL=1, write with cmd_chip=1 → cs=2'b10 for one clk, and cs[0] never asserted.
- reset_n low in mid-WAIT with 5 entries queued → all outputs zero immediately; after release, no bus activity and level=0. Repeat the same scenario with flush instead → same result, sampled one clk later.

Source files
------------

// File: rtl/sid_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// sid_bus_sequencer_if
// Groups the command handshake, SID register bus, read response and status
// signals of the SID bus sequencer.
//   DUAL       : 1 = two SID chips (2-bit cs), 0 = one chip (1-bit cs)
//   FIFO_DEPTH : command FIFO depth, sizes the level field
// Modports:
//   master : the sequencer (takes commands and SID read data; drives the bus,
//            the response and the status)
//   slave  : the environment (loader/player plus the SID core)
// Both ends must be given the same DUAL/FIFO_DEPTH as the sequencer.
// ---------------------------------------------------------------------------
interface sid_bus_sequencer_if #(
  parameter int DUAL       = 0,
  parameter int FIFO_DEPTH = 16
);
  localparam int CS_W  = (DUAL != 0) ? 2 : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       cmd_delay;
  logic              cmd_chip;
  logic              cmd_rd;
  logic [4:0]        cmd_addr;
  logic [7:0]        cmd_data;

  // SID register bus
  logic [CS_W-1:0]   cs;
  logic              we;
  logic [4:0]        addr;
  logic [7:0]        data_out;
  logic [7:0]        sid_rdata;

  // Read response and status
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              busy;
  logic [LVL_W-1:0]  level;

  modport master (
    input  cmd_valid, cmd_delay, cmd_chip, cmd_rd, cmd_addr, cmd_data, sid_rdata,
    output cmd_ready, cs, we, addr, data_out, rsp_valid, rsp_data, busy, level
  );

  modport slave (
    output cmd_valid, cmd_delay, cmd_chip, cmd_rd, cmd_addr, cmd_data, sid_rdata,
    input  cmd_ready, cs, we, addr, data_out, rsp_valid, rsp_data, busy, level
  );
endinterface

// File: rtl/sid_bus_sequencer.sv
// ---------------------------------------------------------------------------
// sid_bus_sequencer
// Bus initiator for the SID register interface. Timed register-access
// commands are queued in a FIFO and issued on the SID bus one at a time,
// each after waiting its delay in ce_1m ticks. Reads return the SID's
// data_out on the response port.
// Ports:
//   clk     : SID core clock
//   reset_n : asynchronous active-low reset
//   ce_1m   : 1 MHz clock enable, one clk wide
//   flush   : synchronous; empties the FIFO and aborts a pending wait
//   bus     : sid_bus_sequencer_if.master (command handshake, SID bus,
//             read response, busy/level status)
// ---------------------------------------------------------------------------
module sid_bus_sequencer #(
  parameter int DUAL       = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce_1m,
  input  logic                  flush,
  sid_bus_sequencer_if.master   bus
);

  localparam int CS_W    = (DUAL != 0) ? 2 : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = AW + 1;
  localparam int ENTRY_W = 31;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // Entry layout: {delay[30:15], chip[14], rd[13], addr[12:8], data[7:0]}
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [15:0] dly,
    input logic        chip,
    input logic        rd,
    input logic [4:0]  a,
    input logic [7:0]  d
  );
    return {dly, chip, rd, a, d};
  endfunction

  // FIFO storage and pointers
  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ENTRY_W-1:0] head_s;
  logic               push_s;
  logic               pop_s;

  // Sequencer state and the entry currently being issued
  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               chip_q, chip_d;
  logic               rd_q, rd_d;
  logic [4:0]         ent_addr_q, ent_addr_d;
  logic [7:0]         ent_data_q, ent_data_d;
  logic [CS_W-1:0]    cs_sel_s;

  // Registered outputs
  logic [CS_W-1:0]    cs_q, cs_d;
  logic               we_q, we_d;
  logic [4:0]         addr_q, addr_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;

  // A command arriving together with flush is dropped; flush also blocks
  // the pop so nothing leaves a FIFO that is being cleared.
  assign push_s = bus.cmd_valid & cmd_ready_q & ~flush;
  assign pop_s  = (state_q == ST_IDLE) & (level_q != '0) & ~flush;
  assign head_s = fifo_mem_q[rd_ptr_q];

  generate
    if (DUAL != 0) begin : g_dual
      assign cs_sel_s = chip_q ? 2'b10 : 2'b01;
    end else begin : g_single
      logic unused_chip_s;
      assign unused_chip_s = chip_q;
      assign cs_sel_s      = 1'b1;
    end
  endgenerate

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= pack_entry(bus.cmd_delay, bus.cmd_chip, bus.cmd_rd,
                                         bus.cmd_addr, bus.cmd_data);
    end
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush only cuts a wait, ACCESS/CAPTURE always finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (ce_1m && (cnt_q == 16'd0)) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        if (rd_q) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Current-entry latch on pop and delay countdown on ce_1m
  always_comb begin
    cnt_d      = cnt_q;
    chip_d     = chip_q;
    rd_d       = rd_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    if (pop_s) begin
      cnt_d      = head_s[30:15];
      chip_d     = head_s[14];
      rd_d       = head_s[13];
      ent_addr_d = head_s[12:8];
      ent_data_d = head_s[7:0];
    end else if ((state_q == ST_WAIT) && flush) begin
      cnt_d = 16'd0;
    end else if ((state_q == ST_WAIT) && ce_1m && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Current-entry registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= 16'd0;
      chip_q     <= 1'b0;
      rd_q       <= 1'b0;
      ent_addr_q <= 5'd0;
      ent_data_q <= 8'd0;
    end else begin
      cnt_q      <= cnt_d;
      chip_q     <= chip_d;
      rd_q       <= rd_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
    end
  end

  // Output logic, decoded from the next state so the registered bus
  // strobes line up exactly with the ACCESS/CAPTURE cycles
  always_comb begin
    cs_d        = '0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_out_d  = data_out_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (state_d == ST_ACCESS) begin
      cs_d       = cs_sel_s;
      we_d       = ~rd_q;
      addr_d     = ent_addr_q;
      data_out_d = ent_data_q;
    end else begin
      cs_d = '0;
      we_d = 1'b0;
    end
    // sid_rdata is taken at the end of the ACCESS cycle, while cs is active
    if (state_d == ST_CAPTURE) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus.sid_rdata;
    end else begin
      rsp_valid_d = 1'b0;
    end
    busy_d      = (level_d != '0) | (state_d != ST_IDLE);
    cmd_ready_d = (level_d != FULL_LVL);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= 5'd0;
      data_out_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cs        = cs_q;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.data_out  = data_out_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.level     = level_q;
  assign bus.cmd_ready = cmd_ready_q;

endmodule
